// File: rtl/mrv1_tw_barrier_pkg.sv
// Shared mrv1 barrier types: per-slot state record sized for the largest supported
// warp count, arrival classification and a one-hot helper.
package mrv1_tw_barrier_pkg;

  localparam int unsigned MRV1_MAX_TW    = 32;
  localparam int unsigned MRV1_MAX_WID_W = 5;

  typedef logic [MRV1_MAX_WID_W-1:0] mrv1_wid_t;
  typedef logic [MRV1_MAX_TW-1:0]    mrv1_wmask_t;

  // Fields are sized for MRV1_MAX_TW; an instance with fewer warps keeps the upper bits at zero.
  typedef struct packed {
    logic        active;
    mrv1_wid_t   size_m1;
    mrv1_wid_t   count;
    mrv1_wmask_t members;
  } mrv1_bar_slot_t;

  localparam mrv1_bar_slot_t MRV1_SLOT_IDLE = '0;

  typedef enum logic [1:0] {
    ARR_NONE,
    ARR_JOIN,
    ARR_COMPLETE,
    ARR_DROP
  } mrv1_arr_kind_t;

  function automatic mrv1_wmask_t mrv1_wid_onehot(input mrv1_wid_t wid);
    mrv1_wmask_t m;
    m      = '0;
    m[wid] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mrv1_tw_barrier_if.sv
// Barrier arrival handshake: a warp presents its ID, target slot and group size.
interface mrv1_tw_barrier_if #(
  parameter int NUM_TW_P       = 8,
  parameter int num_barriers_p = 8
);
  localparam int wid_width_lp        = $clog2(NUM_TW_P);
  localparam int barrier_id_width_lp = $clog2(num_barriers_p);

  logic                           barrier_vld;
  logic                           barrier_rdy;
  logic [wid_width_lp-1:0]        barrier_wid;
  logic [barrier_id_width_lp-1:0] barrier_id;
  logic [wid_width_lp-1:0]        barrier_size_m1;

  modport master (
    output barrier_vld, barrier_wid, barrier_id, barrier_size_m1,
    input  barrier_rdy
  );

  modport slave (
    input  barrier_vld, barrier_wid, barrier_id, barrier_size_m1,
    output barrier_rdy
  );
endinterface

// File: rtl/mrv1_tw_barrier.sv
// Thread-warp barrier unit: counts arrivals per slot, stalls early arrivers and
// releases the whole group in one pulse when the last participant arrives.
module mrv1_tw_barrier
  import mrv1_tw_barrier_pkg::*;
#(
  parameter int NUM_TW_P       = 8,
  parameter int num_barriers_p = 8,
  localparam int wid_width_lp        = $clog2(NUM_TW_P),
  localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mrv1_tw_barrier_if.slave     bar_if,
  input  logic                 flush_i,
  output logic [NUM_TW_P-1:0]  warp_stalled_o,
  output logic                 release_vld_o,
  output logic [NUM_TW_P-1:0]  release_wmask_o,
  output logic                 error_o
);

  logic        accept;
  mrv1_wid_t   wid_ext;
  mrv1_wid_t   size_ext;
  mrv1_wmask_t wid_oh;

  mrv1_wmask_t                slot_rel [num_barriers_p];
  logic [num_barriers_p-1:0]  slot_err;
  logic [num_barriers_p-1:0]  slot_join;

  logic [NUM_TW_P-1:0] stalled_q, stalled_d;
  logic                rel_vld_q, rel_vld_d;
  logic [NUM_TW_P-1:0] rel_mask_q, rel_mask_d;
  logic                err_q, err_d;
  mrv1_wmask_t         rel_full;

  // Flush takes priority over arrivals by refusing them outright.
  assign bar_if.barrier_rdy = rst_ni & ~flush_i;
  assign accept             = bar_if.barrier_vld & bar_if.barrier_rdy;
  assign wid_ext            = MRV1_MAX_WID_W'(bar_if.barrier_wid);
  assign size_ext           = MRV1_MAX_WID_W'(bar_if.barrier_size_m1);
  assign wid_oh             = mrv1_wid_onehot(wid_ext);

  for (genvar gi = 0; gi < num_barriers_p; gi++) begin : g_slot
    mrv1_bar_slot_t slot_q, slot_d;
    mrv1_arr_kind_t kind;
    logic           sel;
    logic           mismatch;

    assign sel = accept && (bar_if.barrier_id == barrier_id_width_lp'(gi));

    always_comb begin
      kind     = ARR_NONE;
      mismatch = 1'b0;
      slot_d   = slot_q;

      if (sel) begin
        if ((slot_q.members & wid_oh) != '0) begin
          kind = ARR_DROP;
        end else if (!slot_q.active) begin
          kind = (size_ext == '0) ? ARR_COMPLETE : ARR_JOIN;
        end else begin
          // A disagreeing size is reported, but the size latched by the first arriver governs.
          mismatch = (size_ext != slot_q.size_m1);
          kind     = (slot_q.count == slot_q.size_m1) ? ARR_COMPLETE : ARR_JOIN;
        end
      end

      case (kind)
        ARR_JOIN: begin
          if (slot_q.active) begin
            slot_d.count   = slot_q.count + mrv1_wid_t'(1);
            slot_d.members = slot_q.members | wid_oh;
          end else begin
            slot_d.active  = 1'b1;
            slot_d.size_m1 = size_ext;
            slot_d.count   = mrv1_wid_t'(1);
            slot_d.members = wid_oh;
          end
        end
        ARR_COMPLETE: slot_d = MRV1_SLOT_IDLE;
        default: ;
      endcase

      if (flush_i) begin
        slot_d = MRV1_SLOT_IDLE;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_q <= MRV1_SLOT_IDLE;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign slot_rel[gi]  = (kind == ARR_COMPLETE) ? (slot_q.members | wid_oh) : '0;
    assign slot_err[gi]  = (kind == ARR_DROP) | mismatch;
    assign slot_join[gi] = (kind == ARR_JOIN);
  end

  always_comb begin
    rel_full = '0;
    for (int i = 0; i < num_barriers_p; i++) begin
      rel_full = rel_full | slot_rel[i];
    end

    rel_vld_d  = |rel_full;
    rel_mask_d = rel_full[NUM_TW_P-1:0];
    err_d      = |slot_err;

    // Released members wake in the same cycle the release pulse is visible.
    stalled_d = stalled_q & ~rel_full[NUM_TW_P-1:0];
    if (|slot_join) begin
      stalled_d = stalled_d | wid_oh[NUM_TW_P-1:0];
    end

    if (flush_i) begin
      stalled_d  = '0;
      rel_vld_d  = 1'b0;
      rel_mask_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stalled_q  <= '0;
      rel_vld_q  <= 1'b0;
      rel_mask_q <= '0;
      err_q      <= 1'b0;
    end else begin
      stalled_q  <= stalled_d;
      rel_vld_q  <= rel_vld_d;
      rel_mask_q <= rel_mask_d;
      err_q      <= err_d;
    end
  end

  if (NUM_TW_P < MRV1_MAX_TW) begin : g_unused_hi
    logic unused_rel_hi;
    assign unused_rel_hi = |rel_full[MRV1_MAX_TW-1:NUM_TW_P];
  end

  assign warp_stalled_o  = stalled_q;
  assign release_vld_o   = rel_vld_q;
  assign release_wmask_o = rel_mask_q;
  assign error_o         = err_q;

endmodule
